// File: rtl/game_ctrl.sv
// game_ctrl: per-frame sequencer for the character and map drawers.
// Walks WAIT_START -> INIT -> IDLE -> REG -> CHECK -> APPLY -> DRAW_MAP -> DRAW_LINK,
// paces each loop to a fixed frame period, guards both draw states with a
// watchdog and counts frame ticks that could not be serviced in time.
module game_ctrl #(
    parameter int FRAME_CYCLES = 833333,
    parameter int CHECK_CYCLES = 2,
    parameter int TIMEOUT      = 131071
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        map_done,
    input  logic        link_done,
    output logic        init,
    output logic        idle,
    output logic        reg_action,
    output logic        apply_action,
    output logic        draw_map,
    output logic        draw_link,
    output logic [15:0] frame_count,
    output logic [7:0]  overruns,
    output logic        error
);

    // Frame timer width and per-state counter width (must also cover CHECK_CYCLES).
    localparam int FW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (TW > 4) ? TW : 4;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CHK_LAST   = CW'(CHECK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_START = 3'd0,
        S_INIT       = 3'd1,
        S_IDLE       = 3'd2,
        S_REG        = 3'd3,
        S_CHECK      = 3'd4,
        S_APPLY      = 3'd5,
        S_DRAW_MAP   = 3'd6,
        S_DRAW_LINK  = 3'd7
    } state_t;

    // Strobe vector order: {init, idle, reg_action, apply_action, draw_map, draw_link}
    localparam logic [5:0] STRB_RESET = 6'b010000;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            pending_q, pending_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [7:0]      overruns_q, overruns_d;
    logic            error_q, error_d;
    logic [5:0]      strb_q, strb_d;

    logic            tick_s;
    logic            done_window_s;
    logic            timeout_s;
    logic            wd_fire_s;
    logic            frame_end_s;

    // Moore decode of the one strobe that belongs to each state.
    function automatic logic [5:0] strobes_for(input state_t s);
        logic [5:0] v;
        case (s)
            S_WAIT_START: v = 6'b010000;
            S_INIT:       v = 6'b100000;
            S_IDLE:       v = 6'b010000;
            S_REG:        v = 6'b001000;
            S_CHECK:      v = 6'b000000;
            S_APPLY:      v = 6'b000100;
            S_DRAW_MAP:   v = 6'b000010;
            S_DRAW_LINK:  v = 6'b000001;
            default:      v = STRB_RESET;
        endcase
        return v;
    endfunction

    // Frame tick: timer is parked at zero until the game has been started.
    assign tick_s        = (state_q != S_WAIT_START) && (frame_q == FRAME_LAST);
    // A done seen on the first cycle of a draw state is left over from the previous frame.
    assign done_window_s = (cnt_q != {CW{1'b0}});
    assign timeout_s     = (cnt_q == TO_LAST);

    // Next-state logic, watchdog decisions and frame-completion detection.
    always_comb begin
        state_d     = state_q;
        wd_fire_s   = 1'b0;
        frame_end_s = 1'b0;
        case (state_q)
            S_WAIT_START: begin
                if (start) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_WAIT_START;
                end
            end
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                if (tick_s || pending_q) begin
                    state_d = S_REG;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REG: state_d = S_CHECK;
            S_CHECK: begin
                if (cnt_q == CHK_LAST) begin
                    state_d = S_APPLY;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_APPLY: state_d = S_DRAW_MAP;
            S_DRAW_MAP: begin
                if (map_done && done_window_s) begin
                    state_d = S_DRAW_LINK;
                end else if (timeout_s) begin
                    state_d   = S_DRAW_LINK;
                    wd_fire_s = 1'b1;
                end else begin
                    state_d = S_DRAW_MAP;
                end
            end
            S_DRAW_LINK: begin
                if (link_done && done_window_s) begin
                    state_d     = S_IDLE;
                    frame_end_s = 1'b1;
                end else if (timeout_s) begin
                    state_d     = S_IDLE;
                    wd_fire_s   = 1'b1;
                    frame_end_s = 1'b1;
                end else begin
                    state_d = S_DRAW_LINK;
                end
            end
            default: state_d = S_WAIT_START;
        endcase
    end

    // Per-state dwell counter, frame timer, pending/overrun bookkeeping and status.
    always_comb begin
        cnt_d         = cnt_q;
        frame_d       = frame_q;
        pending_d     = pending_q;
        overruns_d    = overruns_q;
        frame_count_d = frame_count_q;
        error_d       = error_q;

        // Dwell counter restarts on every state entry and saturates instead of wrapping.
        if (state_d != state_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (state_q == S_WAIT_START) begin
            frame_d = {FW{1'b0}};
        end else if (tick_s) begin
            frame_d = {FW{1'b0}};
        end else begin
            frame_d = frame_q + FW'(1);
        end

        // IDLE consumes a tick or a pending request (a simultaneous tick is absorbed);
        // anywhere else a tick is remembered once and counted as an overrun after that.
        if (state_q == S_IDLE) begin
            if (tick_s || pending_q) begin
                pending_d = 1'b0;
            end else begin
                pending_d = pending_q;
            end
        end else if (tick_s) begin
            if (pending_q) begin
                pending_d = 1'b1;
                if (overruns_q != 8'hFF) begin
                    overruns_d = overruns_q + 8'd1;
                end else begin
                    overruns_d = overruns_q;
                end
            end else begin
                pending_d = 1'b1;
            end
        end else begin
            pending_d = pending_q;
        end

        if (frame_end_s) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end

        if (wd_fire_s) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // Strobes are decoded from the next state so they register in step with it.
    assign strb_d = strobes_for(state_d);

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_WAIT_START;
            cnt_q         <= {CW{1'b0}};
            frame_q       <= {FW{1'b0}};
            pending_q     <= 1'b0;
            frame_count_q <= 16'd0;
            overruns_q    <= 8'd0;
            error_q       <= 1'b0;
            strb_q        <= STRB_RESET;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_q       <= frame_d;
            pending_q     <= pending_d;
            frame_count_q <= frame_count_d;
            overruns_q    <= overruns_d;
            error_q       <= error_d;
            strb_q        <= strb_d;
        end
    end

    assign init         = strb_q[5];
    assign idle         = strb_q[4];
    assign reg_action   = strb_q[3];
    assign apply_action = strb_q[2];
    assign draw_map     = strb_q[1];
    assign draw_link    = strb_q[0];
    assign frame_count  = frame_count_q;
    assign overruns     = overruns_q;
    assign error        = error_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: cycle-exact vector table for the first frame,
// then drawer-model sequences for steady state, watchdog, resets and overruns.
module tb_game_ctrl;

    localparam logic [5:0] ST_INIT  = 6'b100000;
    localparam logic [5:0] ST_IDLE  = 6'b010000;
    localparam logic [5:0] ST_REG   = 6'b001000;
    localparam logic [5:0] ST_APPLY = 6'b000100;
    localparam logic [5:0] ST_MAP   = 6'b000010;
    localparam logic [5:0] ST_LINK  = 6'b000001;
    localparam logic [5:0] ST_NONE  = 6'b000000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT A: FRAME 1024, CHECK 2, TIMEOUT 400 ----------------
    logic reset_a, start_a;
    logic map_man, link_man, map_mdl, link_mdl, model_en;
    logic map_done_a, link_done_a;
    logic init_a, idle_a, reg_a, apply_a, dmap_a, dlink_a, error_a;
    logic [15:0] fc_a;
    logic [7:0]  ov_a;
    logic [5:0]  strb_a;

    assign map_done_a  = model_en ? map_mdl  : map_man;
    assign link_done_a = model_en ? link_mdl : link_man;
    assign strb_a = {init_a, idle_a, reg_a, apply_a, dmap_a, dlink_a};

    game_ctrl #(.FRAME_CYCLES(1024), .CHECK_CYCLES(2), .TIMEOUT(400)) dut_a (
        .clock(clock), .reset(reset_a), .start(start_a),
        .map_done(map_done_a), .link_done(link_done_a),
        .init(init_a), .idle(idle_a), .reg_action(reg_a), .apply_action(apply_a),
        .draw_map(dmap_a), .draw_link(dlink_a),
        .frame_count(fc_a), .overruns(ov_a), .error(error_a)
    );

    // ---------------- DUT B: short frame, long watchdog, drawers silent ----------------
    logic reset_b, start_b;
    logic init_b, idle_b, reg_b, apply_b, dmap_b, dlink_b, error_b;
    logic [15:0] fc_b;
    logic [7:0]  ov_b;
    logic zero_b;
    assign zero_b = 1'b0;

    game_ctrl #(.FRAME_CYCLES(64), .CHECK_CYCLES(2), .TIMEOUT(20000)) dut_b (
        .clock(clock), .reset(reset_b), .start(start_b),
        .map_done(zero_b), .link_done(zero_b),
        .init(init_b), .idle(idle_b), .reg_action(reg_b), .apply_action(apply_b),
        .draw_map(dmap_b), .draw_link(dlink_b),
        .frame_count(fc_b), .overruns(ov_b), .error(error_b)
    );

    // Drawer model: raises done a fixed number of cycles after its strobe rises,
    // drops it as soon as the strobe falls.
    int map_lat = 256;
    int link_lat = 256;
    int map_cnt = 0;
    int link_cnt = 0;
    always @(negedge clock) begin
        map_cnt  <= dmap_a  ? map_cnt + 1  : 0;
        link_cnt <= dlink_a ? link_cnt + 1 : 0;
        map_mdl  <= dmap_a  && (map_cnt + 1 >= map_lat);
        link_mdl <= dlink_a && (link_cnt + 1 >= link_lat);
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        start;
        logic        map_d;
        logic        link_d;
        int          n;
        logic [5:0]  exp_strb;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t vecs[19];
    int   k_b;
    int   cnt;

    initial begin
        // First frame of DUT A, cycle by cycle (frame timer value noted per row).
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1,    ST_IDLE,  16'd0}; // WAIT_START
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1,    ST_INIT,  16'd0}; // INIT, t=0
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1,    ST_IDLE,  16'd0}; // t=1
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1021, ST_IDLE,  16'd0}; // t=1022
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1,    ST_IDLE,  16'd0}; // t=1023 tick
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1,    ST_REG,   16'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1,    ST_NONE,  16'd0}; // CHECK 1
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1,    ST_NONE,  16'd0}; // CHECK 2
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1,    ST_APPLY, 16'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1,    ST_MAP,   16'd0}; // stale done on entry
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1,    ST_MAP,   16'd0}; // 1st-cycle done ignored
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1,    ST_MAP,   16'd0}; // done dropped: stay
        vecs[12] = '{1'b0, 1'b0, 1'b0, 3,    ST_MAP,   16'd0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1,    ST_LINK,  16'd0}; // fresh map done
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1,    ST_LINK,  16'd0}; // stale link ignored
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1,    ST_IDLE,  16'd1}; // t=12
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1,    ST_IDLE,  16'd1}; // t=13
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1010, ST_IDLE,  16'd1}; // t=1023
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1,    ST_REG,   16'd1};

        reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        map_man = 1'b0; link_man = 1'b0; model_en = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_strobes", {26'd0, strb_a}, {26'd0, ST_IDLE});
        check("rst_fc", {16'd0, fc_a}, 32'd0);
        check("rst_ov", {24'd0, ov_a}, 32'd0);
        check("rst_err", {31'd0, error_a}, 32'd0);
        reset_a = 1'b0; reset_b = 1'b0;

        for (int i = 0; i < 19; i++) begin
            start_a  = vecs[i].start;
            map_man  = vecs[i].map_d;
            link_man = vecs[i].link_d;
            repeat (vecs[i].n) @(negedge clock);
            check($sformatf("vec%0d_strb", i), {26'd0, strb_a}, {26'd0, vecs[i].exp_strb});
            check($sformatf("vec%0d_fc", i), {16'd0, fc_a}, {16'd0, vecs[i].exp_fc});
        end
        map_man = 1'b0; link_man = 1'b0;

        // Steady state with 256-cycle drawers: frames complete on time.
        model_en = 1'b1;
        for (int i = 0; i < 6000 && fc_a != 16'd5; i++) @(negedge clock);
        check("steady_fc", {16'd0, fc_a}, 32'd5);
        check("steady_ov", {24'd0, ov_a}, 32'd0);
        check("steady_err", {31'd0, error_a}, 32'd0);

        // Character drawer never answers: watchdog holds draw_link 400 cycles.
        link_lat = 1000000;
        for (int i = 0; i < 3000 && !dlink_a; i++) @(negedge clock);
        check("wd_link_seen", {31'd0, dlink_a}, 32'd1);
        cnt = 0;
        while (dlink_a && cnt < 1000) begin
            cnt = cnt + 1;
            @(negedge clock);
        end
        check("wd_link_len", cnt, 32'd400);
        check("wd_idle", {31'd0, idle_a}, 32'd1);
        check("wd_err", {31'd0, error_a}, 32'd1);
        check("wd_fc", {16'd0, fc_a}, 32'd6);

        // Good frames afterwards: error stays sticky.
        link_lat = 256;
        for (int i = 0; i < 3000 && fc_a != 16'd8; i++) @(negedge clock);
        check("sticky_fc", {16'd0, fc_a}, 32'd8);
        check("sticky_err", {31'd0, error_a}, 32'd1);

        // Reset in the middle of DRAW_LINK.
        for (int i = 0; i < 3000 && !dlink_a; i++) @(negedge clock);
        repeat (10) @(negedge clock);
        check("pre_rst_link", {26'd0, strb_a}, {26'd0, ST_LINK});
        reset_a = 1'b1;
        @(negedge clock);
        reset_a = 1'b0;
        check("rst_link_strb", {26'd0, strb_a}, {26'd0, ST_IDLE});
        check("rst_link_fc", {16'd0, fc_a}, 32'd0);
        check("rst_link_err", {31'd0, error_a}, 32'd0);
        // Without start it must stay parked: no frame tick ever reaches REG.
        cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clock);
            if (strb_a != ST_IDLE) cnt = cnt + 1;
        end
        check("parked", cnt, 32'd0);

        // Reset in the middle of CHECK.
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        check("restart_init", {26'd0, strb_a}, {26'd0, ST_INIT});
        for (int i = 0; i < 1100 && !reg_a; i++) @(negedge clock);
        @(negedge clock);
        check("pre_rst_check", {26'd0, strb_a}, {26'd0, ST_NONE});
        reset_a = 1'b1;
        @(negedge clock);
        reset_a = 1'b0;
        check("rst_check_strb", {26'd0, strb_a}, {26'd0, ST_IDLE});
        check("rst_check_ov", {24'd0, ov_a}, 32'd0);
        repeat (3) @(negedge clock);
        check("rst_check_wait", {26'd0, strb_a}, {26'd0, ST_IDLE});

        // DUT B: stuck in DRAW_MAP; ticks every 64 cycles build up overruns.
        // k=0 is INIT; first tick at k=63 (IDLE), DRAW_MAP from k=68,
        // tick at 127 sets pending, tick at 63+64n gives overruns=n-1.
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        check("b_init", {31'd0, init_b}, 32'd1);
        k_b = 0;
        repeat (130 - k_b) @(negedge clock); k_b = 130;
        check("b_map", {31'd0, dmap_b}, 32'd1);
        check("b_pending_only", {24'd0, ov_b}, 32'd0);
        repeat (200 - k_b) @(negedge clock); k_b = 200;
        check("b_ov1", {24'd0, ov_b}, 32'd1);
        repeat (260 - k_b) @(negedge clock); k_b = 260;
        check("b_ov2", {24'd0, ov_b}, 32'd2);
        repeat (16440 - k_b) @(negedge clock); k_b = 16440;
        check("b_ov254", {24'd0, ov_b}, 32'd254);
        repeat (16460 - k_b) @(negedge clock); k_b = 16460;
        check("b_ov255", {24'd0, ov_b}, 32'd255);
        repeat (20060 - k_b) @(negedge clock); k_b = 20060;
        check("b_ov_sat", {24'd0, ov_b}, 32'd255);
        check("b_still_map", {31'd0, dmap_b}, 32'd1);
        check("b_err0", {31'd0, error_b}, 32'd0);
        repeat (20070 - k_b) @(negedge clock); k_b = 20070;
        check("b_link", {31'd0, dlink_b}, 32'd1);
        check("b_err1", {31'd0, error_b}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
